tone_generator_multi: RTL and testbench

Parametrised multi-channel successor to the single-tone square-wave generator. It provides NUM_CH independent square-wave channels. Each channel's half-period, in clk cycles, is programmed over a simple write port. Period changes are glitch-free because they are double-buffered. Per-channel waves are summed into a registered multi-bit mix feeding the audio path (DAC/PWM stage).

---
 rtl/tone_pkg.sv | 32 +++
 rtl/tone_generator_multi_if.sv | 41 ++++
 rtl/tone_channel.sv | 60 ++++++
 rtl/tone_generator_multi.sv | 84 ++++++++
 tb/tb_tone_generator_multi.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_pkg.sv
// Shared constants, width helpers and channel state type for tone_generator_multi.
// Optional TONE_PWM_OUT_EN adds a delta-sigma pwm_out (see tone_generator_multi.sv).
package tone_pkg;

    localparam int unsigned TONE_NUM_CH   = 4;
    localparam int unsigned TONE_PERIOD_W = 24;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Channel index needs at least one bit even for a single-channel build.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

    typedef struct packed {
        logic [TONE_PERIOD_W-1:0] shadow;
        logic [TONE_PERIOD_W-1:0] active;
        logic [TONE_PERIOD_W-1:0] counter;
        logic                     wave;
    } tone_ch_state_t;

endpackage

// File: rtl/tone_generator_multi_if.sv
// Write port and audio outputs of tone_generator_multi.
// pwm_out exists only when TONE_PWM_OUT_EN is defined.
interface tone_generator_multi_if
    import tone_pkg::*;
#(
    parameter int unsigned NUM_CH   = TONE_NUM_CH,
    parameter int unsigned PERIOD_W = TONE_PERIOD_W
);
    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned MIX_W = clog2(NUM_CH + 1);

    logic                output_enable;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [PERIOD_W-1:0] wr_period;
    logic [NUM_CH-1:0]   square_wave_out;
    logic [MIX_W-1:0]    mix_out;

`ifdef TONE_PWM_OUT_EN
    logic                pwm_out;

    modport master (
        output output_enable, wr_en, wr_ch, wr_period,
        input  square_wave_out, mix_out, pwm_out
    );
    modport slave (
        input  output_enable, wr_en, wr_ch, wr_period,
        output square_wave_out, mix_out, pwm_out
    );
`else
    modport master (
        output output_enable, wr_en, wr_ch, wr_period,
        input  square_wave_out, mix_out
    );
    modport slave (
        input  output_enable, wr_en, wr_ch, wr_period,
        output square_wave_out, mix_out
    );
`endif

endinterface

// File: rtl/tone_channel.sv
// One square-wave channel: double-buffered half-period (shadow -> active at wrap),
// counter and registered wave bit.
module tone_channel
    import tone_pkg::*;
#(
    parameter int unsigned PERIOD_W = TONE_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                wr,
    input  logic [PERIOD_W-1:0] wr_period,
    output logic                wave
);

    typedef struct packed {
        logic [PERIOD_W-1:0] shadow;
        logic [PERIOD_W-1:0] active;
        logic [PERIOD_W-1:0] counter;
        logic                wave;
    } ch_state_t;

    ch_state_t st;
    logic      wrap;

    // >= rather than == so a counter beyond a shrunken period wraps at once.
    assign wrap = (st.counter >= (st.active - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= '0;
        end else begin
            if (wr) begin
                st.shadow <= wr_period;
            end

            if (wr && (st.active == '0)) begin
                st.active  <= wr_period;
                st.counter <= '0;
            end else if (enable && (st.active != '0)) begin
                if (wrap) begin
                    st.counter <= '0;
                    st.active  <= st.shadow;
                    st.wave    <= (st.shadow == '0) ? 1'b0 : ~st.wave;
                end else begin
                    st.counter <= st.counter + 1'b1;
                end
            end

            // Disabled: hold phase at zero so re-enable restarts every channel together.
            if (!enable) begin
                st.counter <= '0;
                st.wave    <= 1'b0;
            end
        end
    end

    assign wave = st.wave;

endmodule

// File: rtl/tone_generator_multi.sv
// Multi-channel square-wave generator: write decode, registered popcount mix and,
// with TONE_PWM_OUT_EN defined, a first-order delta-sigma pwm_out.
module tone_generator_multi
    import tone_pkg::*;
#(
    parameter int unsigned NUM_CH   = TONE_NUM_CH,
    parameter int unsigned PERIOD_W = TONE_PERIOD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    tone_generator_multi_if.slave  bus
);

    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned MIX_W = clog2(NUM_CH + 1);

    logic [NUM_CH-1:0] waves;
    logic [MIX_W-1:0]  pop;
    logic [MIX_W-1:0]  mix_q;

    // Out-of-range indices match no channel, so such writes are dropped.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic wr;
        assign wr = bus.wr_en && (bus.wr_ch == CH_W'(ch));

        tone_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .enable    (bus.output_enable),
            .wr        (wr),
            .wr_period (bus.wr_period),
            .wave      (waves[ch])
        );
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pop = pop + MIX_W'(waves[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mix_q <= '0;
        end else begin
            mix_q <= pop;
        end
    end

    assign bus.square_wave_out = waves;
    assign bus.mix_out         = mix_q;

`ifdef TONE_PWM_OUT_EN
    localparam int unsigned ACC_W = MIX_W + 1;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             pwm_q;

    assign sum = acc + ACC_W'(mix_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            pwm_q <= 1'b0;
        end else if (!bus.output_enable) begin
            acc   <= '0;
            pwm_q <= 1'b0;
        end else if (sum >= ACC_W'(NUM_CH)) begin
            acc   <= sum - ACC_W'(NUM_CH);
            pwm_q <= 1'b1;
        end else begin
            acc   <= sum;
            pwm_q <= 1'b0;
        end
    end

    assign bus.pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_tone_generator_multi.sv
// Self-checking bench for tone_generator_multi: table vectors, per-cycle scoreboard
// against a behavioural model, and timed sequences for period commit corner cases.
module tb_tone_generator_multi;
    import tone_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tone_generator_multi_if #(.NUM_CH(NCH), .PERIOD_W(PW)) bus ();
    tone_generator_multi_if #(.NUM_CH(3),   .PERIOD_W(PW)) bus3 ();

    tone_generator_multi #(.NUM_CH(NCH), .PERIOD_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    tone_generator_multi #(.NUM_CH(3), .PERIOD_W(PW)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NCH-1:0] wave;
        int             mix;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit             we;
        int             ch;
        int unsigned    per;
        logic [NCH-1:0] wave;
        int             mix;
    } vec_t;
    vec_t tbl[14];

    int unsigned    m_sh[NCH];
    int unsigned    m_ac[NCH];
    int unsigned    m_cnt[NCH];
    logic [NCH-1:0] m_wave;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sh[c]  = 0;
            m_ac[c]  = 0;
            m_cnt[c] = 0;
        end
        m_wave = '0;
        sb.delete();
    endtask

    // Next-state of every channel for one clock edge, written from the behavioural rules.
    task automatic model_step(input bit oe, input bit we, input int ch, input int unsigned per);
        logic [NCH-1:0] prev;
        int unsigned    old_sh;
        exp_t           e;
        prev = m_wave;
        for (int c = 0; c < NCH; c++) begin
            old_sh = m_sh[c];
            if (we && ch == c) begin
                m_sh[c] = per;
            end
            if (we && ch == c && m_ac[c] == 0) begin
                m_ac[c]  = per;
                m_cnt[c] = 0;
            end else if (oe && m_ac[c] != 0) begin
                if (m_cnt[c] + 1 >= m_ac[c]) begin
                    m_cnt[c]  = 0;
                    m_ac[c]   = old_sh;
                    m_wave[c] = (old_sh == 0) ? 1'b0 : ~m_wave[c];
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (!oe) begin
                m_cnt[c]  = 0;
                m_wave[c] = 1'b0;
            end
        end
        e.wave = m_wave;
        e.mix  = $countones(prev);
        sb.push_back(e);
    endtask

    task automatic step(input bit oe, input bit we, input int ch, input int unsigned per);
        exp_t e;
        bus.output_enable = oe;
        bus.wr_en         = we;
        bus.wr_ch         = 2'(ch);
        bus.wr_period     = 24'(per);
        model_step(oe, we, ch, per);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        e = sb.pop_front();
        check("sb_wave", int'(bus.square_wave_out), int'(e.wave));
        check("sb_mix", int'(bus.mix_out), e.mix);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        check("rst_wave", int'(bus.square_wave_out), 0);
        check("rst_mix", int'(bus.mix_out), 0);
`ifdef TONE_PWM_OUT_EN
        check("rst_pwm", int'(bus.pwm_out), 0);
`endif
        rst = 1'b0;
        model_reset();
    endtask

    // Steps with enable high until channel c changes; n is the number of edges taken.
    task automatic run_until_toggle(input int c, input int budget, output int n);
        logic prev;
        bit   done;
        prev = bus.square_wave_out[c];
        done = 1'b0;
        n    = 0;
        for (int i = 1; i <= budget && !done; i++) begin
            step(1'b1, 1'b0, 0, 0);
            if (bus.square_wave_out[c] != prev) begin
                n    = i;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL toggle_timeout: ch%0d no edge within %0d cycles", c, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int n;
        int hi;

        bus.output_enable  = 1'b0;
        bus.wr_en          = 1'b0;
        bus.wr_ch          = '0;
        bus.wr_period      = '0;
        bus3.output_enable = 1'b1;
        bus3.wr_en         = 1'b0;
        bus3.wr_ch         = '0;
        bus3.wr_period     = '0;

        // ch0 half-period 4: toggles on edges 4, 8, 12 after the write; mix lags one cycle.
        tbl[0]  = '{1, 0, 4, 4'b0000, 0};
        tbl[1]  = '{0, 0, 0, 4'b0000, 0};
        tbl[2]  = '{0, 0, 0, 4'b0000, 0};
        tbl[3]  = '{0, 0, 0, 4'b0000, 0};
        tbl[4]  = '{0, 0, 0, 4'b0001, 0};
        tbl[5]  = '{0, 0, 0, 4'b0001, 1};
        tbl[6]  = '{0, 0, 0, 4'b0001, 1};
        tbl[7]  = '{0, 0, 0, 4'b0001, 1};
        tbl[8]  = '{0, 0, 0, 4'b0000, 1};
        tbl[9]  = '{0, 0, 0, 4'b0000, 0};
        tbl[10] = '{0, 0, 0, 4'b0000, 0};
        tbl[11] = '{0, 0, 0, 4'b0000, 0};
        tbl[12] = '{0, 0, 0, 4'b0001, 0};
        tbl[13] = '{0, 0, 0, 4'b0001, 1};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, tbl[i].we, tbl[i].ch, tbl[i].per);
            check("tbl_wave", int'(bus.square_wave_out), int'(tbl[i].wave));
            check("tbl_mix", int'(bus.mix_out), tbl[i].mix);
        end

        // Mid-period write: current half-period stays 10, then 3 from the next one.
        do_reset();
        step(1'b1, 1'b1, 0, 10);
        repeat (6) step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 0, 3);
        run_until_toggle(0, 20, n);
        check("p10_tail", n, 3);
        run_until_toggle(0, 20, n);
        check("p3_half_a", n, 3);
        run_until_toggle(0, 20, n);
        check("p3_half_b", n, 3);

        // Commit at wrap: 8 -> 20 (grow), then 20 -> 5 (shrink).
        do_reset();
        step(1'b1, 1'b1, 1, 8);
        step(1'b1, 1'b1, 1, 20);
        run_until_toggle(1, 20, n);
        check("p8_tail", n, 7);
        run_until_toggle(1, 30, n);
        check("p20_half", n, 20);
        step(1'b1, 1'b1, 1, 5);
        run_until_toggle(1, 30, n);
        check("p20_then_write", n + 1, 20);
        run_until_toggle(1, 30, n);
        check("p5_half", n, 5);

        // Period 0 silences at the next wrap; a new write restarts from counter 0.
        do_reset();
        step(1'b1, 1'b1, 2, 4);
        run_until_toggle(2, 10, n);
        check("ch2_first", n, 4);
        step(1'b1, 1'b1, 2, 0);
        run_until_toggle(2, 10, n);
        check("ch2_stop_edge", n, 3);
        check("ch2_stop_low", int'(bus.square_wave_out[2]), 0);
        repeat (12) step(1'b1, 1'b0, 0, 0);
        check("ch2_stays_low", int'(bus.square_wave_out[2]), 0);
        step(1'b1, 1'b1, 2, 6);
        run_until_toggle(2, 10, n);
        check("ch2_restart", n, 6);

        // Disable for 20 cycles, then all channels restart in phase.
        do_reset();
        step(1'b1, 1'b1, 0, 1);
        step(1'b1, 1'b1, 1, 2);
        step(1'b1, 1'b1, 2, 3);
        step(1'b1, 1'b1, 3, 4);
        repeat (5) step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        check("oe_waves_low", int'(bus.square_wave_out), 0);
        step(1'b0, 1'b0, 0, 0);
        check("oe_mix_low", int'(bus.mix_out), 0);
        repeat (18) step(1'b0, 1'b0, 0, 0);
        repeat (6) step(1'b1, 1'b0, 0, 0);
        check("phase_6", int'(bus.square_wave_out), 4'b1010);
        repeat (6) step(1'b1, 1'b0, 0, 0);
        check("phase_12", int'(bus.square_wave_out), 4'b1000);

        // Async reset between clock edges while channels are active.
        do_reset();

        // Three-channel build: index 3 is out of range and must not start anything.
        bus3.wr_en     = 1'b1;
        bus3.wr_ch     = 2'd3;
        bus3.wr_period = 24'd1;
        step(1'b1, 1'b0, 0, 0);
        bus3.wr_en = 1'b0;
        repeat (3) step(1'b1, 1'b0, 0, 0);
        check("oor_ignored", int'(bus3.square_wave_out), 0);
        bus3.wr_en     = 1'b1;
        bus3.wr_ch     = 2'd2;
        bus3.wr_period = 24'd1;
        step(1'b1, 1'b0, 0, 0);
        bus3.wr_en = 1'b0;
        step(1'b1, 1'b0, 0, 0);
        check("ch3build_ch2", int'(bus3.square_wave_out), 3'b100);

`ifdef TONE_PWM_OUT_EN
        // Two anti-phase P=1 pairs keep mix at 2; density must be 1/2.
        do_reset();
        step(1'b1, 1'b1, 0, 1);
        step(1'b1, 1'b1, 1, 1);
        step(1'b1, 1'b1, 2, 1);
        step(1'b1, 1'b1, 3, 1);
        step(1'b1, 1'b0, 0, 0);
        hi = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b0, 0, 0);
            check("pwm_mix_hold", int'(bus.mix_out), 2);
            if (bus.pwm_out) hi++;
        end
        checks++;
        if (hi < 199 || hi > 201) begin
            failures++;
            $display("FAIL pwm_density: got %0d high cycles expected 200+-1", hi);
        end
        do_reset();
`else
        hi = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
